shot_deploy_scheduler: RTL and testbench

- Sequences firing for the player's shot pool. It turns the raw shoot request into one-cycle deploy pulses on a free shot slot, choosing slots round-robin.
- It enforces a frame-based fire cooldown, with a normal interval and a rapid-fire interval.
- It tracks slot occupancy until each shot is freed by a bird hit or by leaving the screen.
- It sits between the player/switch inputs and the shot pool, driving the pool's per-slot deploy bus.

---
 rtl/shot_deploy_scheduler.sv | 148 ++++++++++++++
 tb/tb_shot_deploy_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/shot_deploy_scheduler.sv
// Shot deploy scheduler: turns the shoot request into round-robin, cooldown-paced deploy pulses and tracks slot occupancy.
// Optional macro SHOT_SCHED_STATS_EN adds a saturating shots_fired counter output.
`timescale 1ns/1ps
module shot_deploy_scheduler #(
    parameter int NUM_SLOTS             = 8,
    parameter int COOLDOWN_FRAMES       = 16,
    parameter int RAPID_COOLDOWN_FRAMES = 4,
    localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int SW = $clog2(NUM_SLOTS + 1),
    localparam int CD_MAX = (COOLDOWN_FRAMES > RAPID_COOLDOWN_FRAMES) ? COOLDOWN_FRAMES : RAPID_COOLDOWN_FRAMES,
    localparam int CW = $clog2(CD_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 shoot,
    input  logic                 rapid_fire,
    input  logic                 player_active,
    input  logic [NUM_SLOTS-1:0] SingleHitPulse_shots,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic [NUM_SLOTS-1:0] deploy_shot,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic [SW-1:0]        shots_in_flight,
    output logic                 fire_ready,
    output logic [1:0]           state_dbg,
    output logic [CW-1:0]        cooldown_dbg,
    output logic [PW-1:0]        rr_ptr_dbg
`ifdef SHOT_SCHED_STATS_EN
    ,
    output logic [15:0]          shots_fired
`endif
);

    // Handshake: shoot is a level request latched into pending; a strobe in IDLE
    // accepts it, and deploy_shot is a single-cycle one-hot pulse with no back-pressure.
    typedef enum logic [1:0] {IDLE, SELECT, DEPLOY, COOLDOWN} state_t;

    localparam logic [NUM_SLOTS-1:0] ONE_HOT_0 = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

    state_t         state;
    logic           pending;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  sel;
    logic [CW-1:0]  cooldown;
    logic [PW-1:0]  sel_next;
    logic           found;
    int             idx;
    logic [SW-1:0]  busy_count;

    // Round-robin search from rr_ptr over the registered busy bits, so a slot
    // freed during SELECT only becomes a candidate on the next selection.
    always_comb begin
        sel_next = rr_ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_SLOTS;
            if (!found && !slot_busy[PW'(idx)]) begin
                found    = 1'b1;
                sel_next = PW'(idx);
            end
        end
    end

    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            busy_count = busy_count + SW'(slot_busy[i]);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= IDLE;
            pending         <= 1'b0;
            rr_ptr          <= '0;
            sel             <= '0;
            cooldown        <= '0;
            deploy_shot     <= '0;
            slot_busy       <= '0;
            shots_in_flight <= '0;
            fire_ready      <= 1'b0;
        end else begin
            fire_ready      <= (state == IDLE) && player_active && (slot_busy != '1);
            shots_in_flight <= busy_count;
            // deploy_shot is only non-zero in DEPLOY, so the set overrides a same-cycle free.
            slot_busy       <= (slot_busy & ~(SingleHitPulse_shots | slot_done)) | deploy_shot;
            deploy_shot     <= '0;

            if (state == DEPLOY) begin
                rr_ptr <= (sel == PW'(NUM_SLOTS - 1)) ? '0 : sel + PW'(1);
            end

            if (!player_active) begin
                state    <= IDLE;
                cooldown <= '0;
                pending  <= 1'b0;
            end else begin
                if (shoot) begin
                    pending <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (startOfFrame && (pending || shoot) && (slot_busy != '1)) begin
                            state <= SELECT;
                        end
                    end
                    SELECT: begin
                        sel         <= sel_next;
                        deploy_shot <= ONE_HOT_0 << sel_next;
                        state       <= DEPLOY;
                    end
                    DEPLOY: begin
                        pending  <= 1'b0;
                        cooldown <= rapid_fire ? CW'(RAPID_COOLDOWN_FRAMES) : CW'(COOLDOWN_FRAMES);
                        state    <= COOLDOWN;
                    end
                    COOLDOWN: begin
                        if (startOfFrame) begin
                            if (cooldown == CW'(1) || cooldown == '0) begin
                                cooldown <= '0;
                                state    <= IDLE;
                            end else begin
                                cooldown <= cooldown - CW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SHOT_SCHED_STATS_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shots_fired <= '0;
        end else if (state == DEPLOY && shots_fired != 16'hFFFF) begin
            shots_fired <= shots_fired + 16'd1;
        end
    end
`endif

    assign state_dbg    = state;
    assign cooldown_dbg = cooldown;
    assign rr_ptr_dbg   = rr_ptr;

endmodule

// File: tb/tb_shot_deploy_scheduler.sv
// Directed bench for shot_deploy_scheduler: cadence, round-robin, set-wins race, pending and abort behaviour.
`timescale 1ns/1ps
module tb_shot_deploy_scheduler;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        shoot;
    logic        rapid_fire;
    logic        player_active;
    logic [7:0]  SingleHitPulse_shots;
    logic [7:0]  slot_done;
    logic [7:0]  deploy_shot;
    logic [7:0]  slot_busy;
    logic [3:0]  shots_in_flight;
    logic        fire_ready;
    logic [1:0]  state_dbg;
    logic [4:0]  cooldown_dbg;
    logic [2:0]  rr_ptr_dbg;
`ifdef SHOT_SCHED_STATS_EN
    logic [15:0] shots_fired;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shot_deploy_scheduler dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .shoot                (shoot),
        .rapid_fire           (rapid_fire),
        .player_active        (player_active),
        .SingleHitPulse_shots (SingleHitPulse_shots),
        .slot_done            (slot_done),
        .deploy_shot          (deploy_shot),
        .slot_busy            (slot_busy),
        .shots_in_flight      (shots_in_flight),
        .fire_ready           (fire_ready),
        .state_dbg            (state_dbg),
        .cooldown_dbg         (cooldown_dbg),
        .rr_ptr_dbg           (rr_ptr_dbg)
`ifdef SHOT_SCHED_STATS_EN
        ,
        .shots_fired          (shots_fired)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_free(input logic [7:0] done_vec, input logic [7:0] hit_vec);
        slot_done            = done_vec;
        SingleHitPulse_shots = hit_vec;
        tick();
        slot_done            = '0;
        SingleHitPulse_shots = '0;
    endtask

    // One 10-cycle frame: strobe in cycle 0, hit2 driven on the hits in cycle 2.
    task automatic run_frame(input logic [7:0] hit2, output logic [7:0] dep,
                             output int off, output int ndep);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        dep  = '0;
        off  = -1;
        ndep = 0;
        for (int k = 1; k <= 9; k++) begin
            SingleHitPulse_shots = (k == 2) ? hit2 : 8'h00;
            if (deploy_shot != 8'h00) begin
                dep = dep | deploy_shot;
                ndep++;
                if (off < 0) off = k;
            end
            tick();
        end
        SingleHitPulse_shots = '0;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp_dep,
                               input logic [7:0] dep, input int off, input int ndep);
        if (exp_dep != 8'h00) begin
            check({tag, "_count"}, ndep, 1);
            check({tag, "_deploy"}, {24'h0, dep}, {24'h0, exp_dep});
            check({tag, "_offset"}, off, 2);
        end else begin
            check({tag, "_nodeploy"}, ndep, 0);
        end
    endtask

    initial begin
        int         fire_frame[8];
        logic [7:0] exp_dep;
        logic [7:0] dep;
        int         off;
        int         nd;

        fire_frame = '{0, 17, 22, 27, 32, 37, 42, 47};

        resetN = 1'b0;
        startOfFrame = 1'b0;
        shoot = 1'b0;
        rapid_fire = 1'b0;
        player_active = 1'b0;
        SingleHitPulse_shots = '0;
        slot_done = '0;
        tick();
        tick();

        check("rst_deploy", {24'h0, deploy_shot}, 32'h0);
        check("rst_busy", {24'h0, slot_busy}, 32'h0);
        check("rst_sif", {28'h0, shots_in_flight}, 32'h0);
        check("rst_fire_ready", {31'h0, fire_ready}, 32'h0);
        check("rst_state", {30'h0, state_dbg}, 32'h0);
        check("rst_cooldown", {27'h0, cooldown_dbg}, 32'h0);
        check("rst_rr_ptr", {29'h0, rr_ptr_dbg}, 32'h0);

        player_active = 1'b1;
        shoot = 1'b1;
        resetN = 1'b1;
        tick();
        tick();
        check("fire_ready_after_reset", {31'h0, fire_ready}, 32'h1);

        // Normal cadence (16) for the first shot, rapid (4) from the second load on.
        for (int f = 0; f <= 54; f++) begin
            if (f == 17) rapid_fire = 1'b1;
            exp_dep = 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (f == fire_frame[j]) exp_dep = 8'd1 << j;
            end
            run_frame(8'h00, dep, off, nd);
            check_frame($sformatf("frame%0d", f), exp_dep, dep, off, nd);
            if (f == 0)  check("sif_after_first", {28'h0, shots_in_flight}, 32'd1);
            if (f == 5)  check("fire_ready_in_cooldown", {31'h0, fire_ready}, 32'h0);
            if (f == 17) check("sif_after_second", {28'h0, shots_in_flight}, 32'd2);
        end
        check("full_sif", {28'h0, shots_in_flight}, 32'd8);
        check("full_fire_ready", {31'h0, fire_ready}, 32'h0);
        check("full_busy", {24'h0, slot_busy}, 32'hFF);
        check("full_rr_ptr", {29'h0, rr_ptr_dbg}, 32'd0);

        // Free slot 3 while full: next strobe must pick slot 3, rr_ptr to 4.
        pulse_free(8'h08, 8'h00);
        tick();
        check("free3_busy", {24'h0, slot_busy}, 32'hF7);
        check("free3_fire_ready", {31'h0, fire_ready}, 32'h1);
        run_frame(8'h00, dep, off, nd);
        check_frame("refill3", 8'h08, dep, off, nd);
        check("refill3_rr_ptr", {29'h0, rr_ptr_dbg}, 32'd4);
        check("refill3_busy", {24'h0, slot_busy}, 32'hFF);

        // Free slot 2, wait out the cooldown, then hit slot 2 during its DEPLOY.
        pulse_free(8'h04, 8'h00);
        for (int f = 0; f < 4; f++) begin
            run_frame(8'h00, dep, off, nd);
            check_frame($sformatf("cd2_frame%0d", f), 8'h00, dep, off, nd);
        end
        run_frame(8'h04, dep, off, nd);
        check_frame("race2", 8'h04, dep, off, nd);
        check("race2_busy", {24'h0, slot_busy}, 32'hFF);
        check("race2_rr_ptr", {29'h0, rr_ptr_dbg}, 32'd3);

        // Drop player_active to flush pending and cooldown; slot_busy unaffected.
        shoot = 1'b0;
        player_active = 1'b0;
        tick();
        player_active = 1'b1;
        check("flush_state", {30'h0, state_dbg}, 32'h0);
        check("flush_cooldown", {27'h0, cooldown_dbg}, 32'h0);
        check("flush_busy", {24'h0, slot_busy}, 32'hFF);

        // Single-cycle shoot pulse mid-frame gives exactly one deploy.
        pulse_free(8'h00, 8'h20);
        run_frame(8'h00, dep, off, nd);
        check_frame("no_request", 8'h00, dep, off, nd);
        shoot = 1'b1;
        tick();
        shoot = 1'b0;
        run_frame(8'h00, dep, off, nd);
        check_frame("pulse_shot", 8'h20, dep, off, nd);
        check("pulse_shot_rr_ptr", {29'h0, rr_ptr_dbg}, 32'd6);
        pulse_free(8'h01, 8'h00);
        for (int f = 0; f < 6; f++) begin
            run_frame(8'h00, dep, off, nd);
            check_frame($sformatf("after_pulse%0d", f), 8'h00, dep, off, nd);
        end
        check("after_pulse_fire_ready", {31'h0, fire_ready}, 32'h1);
        check("after_pulse_busy", {24'h0, slot_busy}, 32'hFE);

        // Abort in SELECT: no deploy, IDLE, cooldown 0, busy untouched.
        shoot = 1'b1;
        startOfFrame = 1'b1;
        tick();
        shoot = 1'b0;
        startOfFrame = 1'b0;
        player_active = 1'b0;
        check("abort_in_select", {30'h0, state_dbg}, 32'd1);
        tick();
        check("abort_deploy", {24'h0, deploy_shot}, 32'h0);
        check("abort_state", {30'h0, state_dbg}, 32'h0);
        check("abort_cooldown", {27'h0, cooldown_dbg}, 32'h0);
        check("abort_busy", {24'h0, slot_busy}, 32'hFE);
        player_active = 1'b1;
        tick();
        check("abort_deploy_late", {24'h0, deploy_shot}, 32'h0);
        run_frame(8'h00, dep, off, nd);
        check_frame("abort_followup", 8'h00, dep, off, nd);
        check("abort_busy_final", {24'h0, slot_busy}, 32'hFE);

`ifdef SHOT_SCHED_STATS_EN
        check("shots_fired", {16'h0, shots_fired}, 32'd11);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
